trap_pc: RTL and testbench
==========================

# trap_pc

Parametrised program-counter unit with prioritised, vectored interrupt entry and `mret` return for the audio SoC core. It holds the fetch address and advances it from the core-supplied next address. It latches edge-triggered interrupt requests from `NUM_IRQ` sources and redirects fetch to a per-source vector while saving the return address and cause. It sits between the core's next-PC mux and the instruction fetch port.

## Interface
Parameters:
- `XLEN`, 32: address/data width.
- `NUM_IRQ`, 4: interrupt source count, 1..16.
- `RESET_VEC`, 32'h0: PC value after reset.
- `TRAP_BASE`, 32'h20: base of the trap vector table.
- `VECTORED`, 1: 1 = target `TRAP_BASE + 4*id`; 0 = target `TRAP_BASE` for all sources.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold all architectural state this cycle.
- `next_pc`  in  XLEN  normal next address, usually pc+4 or a branch target.
- `mret`  in  1  single-cycle return-from-trap request.
- `irq`  in  NUM_IRQ  interrupt request lines, level inputs, edge-detected internally.
- `pc`  out  XLEN  current fetch address (register).
- `mepc`  out  XLEN  saved return address (register).
- `mcause`  out  XLEN  bit XLEN-1 = interrupt flag, low bits = source id (register).
- `in_trap`  out  1  high from trap entry until `mret` is accepted; equals the inverse of the internal MIE.
- `irq_ack`  out  NUM_IRQ  one-hot, one-cycle pulse naming the source just taken (register).

## Operation
- Edge capture: `irq_q` registers `irq`. `pend[i]` is set when `irq[i] & ~irq_q[i]` and cleared when source i is taken. If a set and a clear hit the same bit in one cycle, the set wins. Capture continues during `stall` and while `in_trap=1`.
- Priority: the lowest index among set `pend` bits wins.
- Per-edge decision, evaluated in this priority order:
  1. `stall=1`: `pc`, `mepc`, `mcause` and MIE hold. `mret` is ignored. `irq_ack` is 0.
  2. `mret=1`: `pc <= mepc`, MIE <= 1. No trap is taken this edge, even with pending bits set.
  3. `|pend & MIE`: trap entry. `pc <= target(id)`, `mepc <= next_pc`, `mcause <= {1'b1, zero-extended id}`, MIE <= 0, `irq_ack[id] <= 1`, `pend[id]` cleared.
  4. Otherwise: `pc <= next_pc`.
- `irq_ack` is 0 on every edge that is not a trap entry.
- Nesting is not supported. While MIE=0, new requests only accumulate in `pend`.
- `mret` with `in_trap=0` still loads `pc <= mepc`; MIE stays 1.
- Target arithmetic is done modulo 2^XLEN; no overflow check is performed.

## Timing
- Reset values: `pc = RESET_VEC`; `mepc`, `mcause`, `irq_ack`, `pend` and `irq_q` = 0; MIE = 1 (`in_trap = 0`).
- Rising edge of `irq[i]` sampled at edge N sets `pend[i]` at edge N. The trap is taken at edge N+1 if MIE=1 and `stall=0`, so `pc` shows the vector after N+1.
- `irq_ack` is high for exactly the one cycle following the trap edge.
- `mret` at edge M: `pc = mepc` after M. A waiting pending request is taken at edge M+1 at the earliest.
- Reset asserted mid-trap forces all reset values immediately. Pending requests are lost.

## Test plan
- Reset, then `next_pc` stepping 0x4, 0x8, 0xC with no irq -> `pc` follows one cycle later. `mepc=0`, `mcause=0`, `in_trap=0`.
- `irq[2]` rising while `next_pc=0x104` (VECTORED=1) -> `pc=0x28`, `mepc=0x104`, `mcause=0x80000002`, `irq_ack=4'b0100` for one cycle, `in_trap=1`.
- `irq[0]` and `irq[3]` rise together -> source 0 taken first (`pc=0x20`). After `mret`, source 3 is taken one edge later (`pc=0x2C`, `mcause=0x80000003`).
- `irq[1]` rises while `in_trap=1` -> no redirect. `mret` -> `pc=mepc`. Next edge -> trap to 0x24.
- `stall` held 3 cycles with `irq[1]` rising inside the window -> `pc` frozen, `irq_ack=0` throughout. Trap is taken on the first edge with `stall=0`.
- VECTORED=0, `irq[3]` -> `pc=0x20`, `mcause=0x80000003`. Assert `rst_n=0` mid-trap -> `pc=0`, `in_trap=0`, `pend` cleared.

Source files
------------

// File: rtl/trap_pc.sv
// rtl/trap_pc.sv - program counter with edge-captured, prioritised, vectored interrupt entry and mret return
module trap_pc #(
  parameter int              XLEN      = 32,
  parameter int              NUM_IRQ   = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_BASE = XLEN'(32'h20),
  parameter bit              VECTORED  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [XLEN-1:0]    next_pc,
  input  logic               mret,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    mcause,
  output logic               in_trap,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  // RUN means interrupts enabled (MIE=1); TRAP means inside a handler
  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } mode_t;

  mode_t              mode_q, mode_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] take_oh;
  logic [IDW-1:0]     id;
  logic               take;
  logic [XLEN-1:0]    target;
  logic [XLEN-1:0]    cause;
  logic [XLEN-1:0]    pc_d;
  logic [XLEN-1:0]    mepc_d;
  logic [XLEN-1:0]    mcause_d;

  assign rise    = irq & ~irq_q;
  assign in_trap = (mode_q == TRAP);

  // Lowest set index wins: scan high to low so the last hit is the lowest
  always_comb begin
    id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) id = IDW'(i);
    end
  end

  always_comb begin
    target = TRAP_BASE;
    if (VECTORED) target = TRAP_BASE + (XLEN'(id) << 2);
  end

  always_comb begin
    cause           = '0;
    cause[IDW-1:0]  = id;
    cause[XLEN-1]   = 1'b1;
  end

  always_comb begin
    mode_d   = mode_q;
    pc_d     = pc;
    mepc_d   = mepc;
    mcause_d = mcause;
    take     = 1'b0;
    if (!stall) begin
      if (mret) begin
        pc_d   = mepc;
        mode_d = RUN;
      end else if ((|pend) && (mode_q == RUN)) begin
        take     = 1'b1;
        pc_d     = target;
        mepc_d   = next_pc;
        mcause_d = cause;
        mode_d   = TRAP;
      end else begin
        pc_d = next_pc;
      end
    end
  end

  // A new edge on the source being taken re-arms it: set beats clear
  always_comb begin
    take_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      take_oh[i] = take && (id == IDW'(i));
    end
    pend_d = (pend & ~take_oh) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= RUN;
      pc      <= RESET_VEC;
      mepc    <= '0;
      mcause  <= '0;
      irq_ack <= '0;
      pend    <= '0;
      irq_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      pc      <= pc_d;
      mepc    <= mepc_d;
      mcause  <= mcause_d;
      irq_ack <= take_oh;
      pend    <= pend_d;
      irq_q   <= irq;
    end
  end

endmodule

// File: tb/tb_trap_pc.sv
// tb/tb_trap_pc.sv - directed scoreboard bench for trap_pc, vectored and flat instances side by side
module tb_trap_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] next_pc;
  logic        mret;
  logic [3:0]  irq;

  logic [31:0] pc, mepc, mcause;
  logic        in_trap;
  logic [3:0]  irq_ack;
  logic [31:0] pc_f, mepc_f, mcause_f;
  logic        in_trap_f;
  logic [3:0]  irq_ack_f;

  int n_total = 0;
  int n_pass  = 0;
  int n_step  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        trap;
    logic [3:0]  ack;
    logic [31:0] pcn;
  } exp_t;

  exp_t sb[$];

  trap_pc dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .next_pc(next_pc), .mret(mret), .irq(irq),
    .pc(pc), .mepc(mepc), .mcause(mcause), .in_trap(in_trap), .irq_ack(irq_ack)
  );

  trap_pc #(.VECTORED(1'b0)) dut_flat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .next_pc(next_pc), .mret(mret), .irq(irq),
    .pc(pc_f), .mepc(mepc_f), .mcause(mcause_f), .in_trap(in_trap_f), .irq_ack(irq_ack_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".pc"},      pc,             e.pc);
    chk({tag, ".mepc"},    mepc,           e.mepc);
    chk({tag, ".mcause"},  mcause,         e.mcause);
    chk({tag, ".in_trap"}, 32'(in_trap),   32'(e.trap));
    chk({tag, ".irq_ack"}, 32'(irq_ack),   32'(e.ack));
    chk({tag, ".pc_flat"}, pc_f,           e.pcn);
  endtask

  // Drive one cycle of stimulus, queue what the DUT must show after the edge, then compare
  task automatic step(input logic st, input logic [31:0] np, input logic mr, input logic [3:0] iq,
                      input logic [31:0] e_pc, input logic [31:0] e_mepc, input logic [31:0] e_mc,
                      input logic e_trap, input logic [3:0] e_ack, input logic [31:0] e_pcn);
    exp_t e;
    @(negedge clk);
    stall   = st;
    next_pc = np;
    mret    = mr;
    irq     = iq;
    sb.push_back('{pc: e_pc, mepc: e_mepc, mcause: e_mc, trap: e_trap, ack: e_ack, pcn: e_pcn});
    @(posedge clk);
    #1;
    n_step++;
    if (sb.size() == 0) begin
      chk($sformatf("s%0d.queue", n_step), 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk_all($sformatf("s%0d", n_step), e);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"},        pc,            32'h0);
    chk({tag, ".mepc"},      mepc,          32'h0);
    chk({tag, ".mcause"},    mcause,        32'h0);
    chk({tag, ".in_trap"},   32'(in_trap),  32'h0);
    chk({tag, ".irq_ack"},   32'(irq_ack),  32'h0);
    chk({tag, ".pc_flat"},   pc_f,          32'h0);
    chk({tag, ".mepc_f"},    mepc_f,        32'h0);
    chk({tag, ".mcause_f"},  mcause_f,      32'h0);
    chk({tag, ".in_trap_f"}, 32'(in_trap_f), 32'h0);
    chk({tag, ".irq_ack_f"}, 32'(irq_ack_f), 32'h0);
  endtask

  localparam logic [31:0] C0 = 32'h8000_0000;
  localparam logic [31:0] C1 = 32'h8000_0001;
  localparam logic [31:0] C2 = 32'h8000_0002;
  localparam logic [31:0] C3 = 32'h8000_0003;

  initial begin
    rst_n   = 1'b0;
    stall   = 1'b0;
    next_pc = '0;
    mret    = 1'b0;
    irq     = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // plain stepping
    step(0, 32'h4,   0, 4'b0000, 32'h4,   32'h0,   32'h0, 0, 4'b0000, 32'h4);
    step(0, 32'h8,   0, 4'b0000, 32'h8,   32'h0,   32'h0, 0, 4'b0000, 32'h8);
    step(0, 32'hC,   0, 4'b0000, 32'hC,   32'h0,   32'h0, 0, 4'b0000, 32'hC);

    // irq[2]: captured on one edge, taken on the next
    step(0, 32'h100, 0, 4'b0100, 32'h100, 32'h0,   32'h0, 0, 4'b0000, 32'h100);
    step(0, 32'h104, 0, 4'b0100, 32'h28,  32'h104, C2,    1, 4'b0100, 32'h20);
    step(0, 32'h2C,  0, 4'b0100, 32'h2C,  32'h104, C2,    1, 4'b0000, 32'h2C);
    step(0, 32'h30,  1, 4'b0000, 32'h104, 32'h104, C2,    0, 4'b0000, 32'h104);

    // irq[0] and irq[3] together: 0 first, 3 one edge after mret
    step(0, 32'h108, 0, 4'b1001, 32'h108, 32'h104, C2,    0, 4'b0000, 32'h108);
    step(0, 32'h10C, 0, 4'b1001, 32'h20,  32'h10C, C0,    1, 4'b0001, 32'h20);
    step(0, 32'h24,  0, 4'b1001, 32'h24,  32'h10C, C0,    1, 4'b0000, 32'h24);
    step(0, 32'h28,  1, 4'b1001, 32'h10C, 32'h10C, C0,    0, 4'b0000, 32'h10C);
    step(0, 32'h110, 0, 4'b1001, 32'h2C,  32'h110, C3,    1, 4'b1000, 32'h20);
    step(0, 32'h30,  1, 4'b0000, 32'h110, 32'h110, C3,    0, 4'b0000, 32'h110);

    // irq[1] rising inside a handler waits for mret
    step(0, 32'h114, 0, 4'b0100, 32'h114, 32'h110, C3,    0, 4'b0000, 32'h114);
    step(0, 32'h118, 0, 4'b0100, 32'h28,  32'h118, C2,    1, 4'b0100, 32'h20);
    step(0, 32'h2C,  0, 4'b0110, 32'h2C,  32'h118, C2,    1, 4'b0000, 32'h2C);
    step(0, 32'h30,  0, 4'b0110, 32'h30,  32'h118, C2,    1, 4'b0000, 32'h30);
    step(0, 32'h34,  1, 4'b0110, 32'h118, 32'h118, C2,    0, 4'b0000, 32'h118);
    step(0, 32'h11C, 0, 4'b0110, 32'h24,  32'h11C, C1,    1, 4'b0010, 32'h20);
    step(0, 32'h28,  1, 4'b0000, 32'h11C, 32'h11C, C1,    0, 4'b0000, 32'h11C);

    // stall window with irq[1] rising inside; mret ignored under stall
    step(1, 32'h200, 0, 4'b0000, 32'h11C, 32'h11C, C1,    0, 4'b0000, 32'h11C);
    step(1, 32'h200, 0, 4'b0010, 32'h11C, 32'h11C, C1,    0, 4'b0000, 32'h11C);
    step(1, 32'h200, 0, 4'b0010, 32'h11C, 32'h11C, C1,    0, 4'b0000, 32'h11C);
    step(0, 32'h120, 0, 4'b0010, 32'h24,  32'h120, C1,    1, 4'b0010, 32'h20);
    step(1, 32'h28,  1, 4'b0000, 32'h24,  32'h120, C1,    1, 4'b0000, 32'h20);
    step(0, 32'h28,  1, 4'b0000, 32'h120, 32'h120, C1,    0, 4'b0000, 32'h120);

    // mret outside a trap still reloads mepc
    step(0, 32'h300, 0, 4'b0000, 32'h300, 32'h120, C1,    0, 4'b0000, 32'h300);
    step(0, 32'h304, 1, 4'b0000, 32'h120, 32'h120, C1,    0, 4'b0000, 32'h120);

    // irq[3]: flat instance lands on the table base
    step(0, 32'h304, 0, 4'b1000, 32'h304, 32'h120, C1,    0, 4'b0000, 32'h304);
    step(0, 32'h308, 0, 4'b1000, 32'h2C,  32'h308, C3,    1, 4'b1000, 32'h20);
    chk("flat.mcause", mcause_f, C3);
    chk("flat.mepc",   mepc_f,   32'h308);
    step(0, 32'h24,  0, 4'b1001, 32'h24,  32'h308, C3,    1, 4'b0000, 32'h24);

    // asynchronous reset mid-trap with irq[0] pending
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    irq   = '0;
    rst_n = 1'b1;
    step(0, 32'h4,   0, 4'b0000, 32'h4,   32'h0,   32'h0, 0, 4'b0000, 32'h4);
    step(0, 32'h8,   0, 4'b0000, 32'h8,   32'h0,   32'h0, 0, 4'b0000, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
